// File: rtl/rv_pkg.sv
// Shared definitions for the rv32im_zbb pipeline: fetch FSM states, NOP encoding
// and the default reset vector.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } if_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer holding {pc, instr} entries; head is the oldest entry.
// A flush empties the buffer and wins over a simultaneous push.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push,
    input  logic [63:0]                  push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH):0]       count,
    output logic [63:0]                  head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: the top masks the head whenever count is zero.
    always_ff @(posedge clk_i) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches over req/gnt/rvalid and buffers words
// for decode. Define IF_PERF_CNT_EN to add delivered-instruction and bubble counters.
module if_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] instr_pc_o,
    output logic [31:0] if_fetch_cnt_o,
    output logic [31:0] if_bubble_cnt_o
`else
    output logic [31:0] instr_pc_o
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    if_state_t        state;
    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] discard_next;
    logic [CNT_W-1:0] fifo_count;
    logic [63:0]      fifo_head;
    logic [CNT_W:0]   credit_used;
    logic             pop;
    logic             push;
    logic             gnt_fire;

    assign instr_valid_o = (fifo_count != '0);
    assign instr_o       = instr_valid_o ? fifo_head[31:0]  : NOP_INSTR;
    assign instr_pc_o    = instr_valid_o ? fifo_head[63:32] : 32'h0;
    assign pop           = instr_valid_o && instr_ready_i;

    // Buffer slots already spoken for, crediting the word decode takes this cycle.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - (CNT_W + 1)'(pop);
    assign imem_req_o  = (state != BOOT) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign imem_addr_o = fetch_pc;
    assign gnt_fire    = imem_req_o && imem_gnt_i;

    assign push             = imem_rvalid_i && (discard == '0) && !redirect_i;
    assign outstanding_next = outstanding + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid_i);

    // A redirect marks every word still in flight after this edge as old-path.
    always_comb begin
        discard_next = discard;
        if (redirect_i) begin
            discard_next = outstanding_next;
        end else if (imem_rvalid_i && (discard != '0)) begin
            discard_next = discard - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            discard     <= discard_next;
            if (redirect_i) begin
                fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
                resp_pc  <= redirect_pc_i & 32'hFFFF_FFFC;
                state    <= (discard_next != '0) ? DRAIN : RUN;
            end else begin
                if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
                // Responses return in order, so the next kept word belongs to resp_pc.
                if (push)     resp_pc  <= resp_pc + 32'd4;
                case (state)
                    BOOT:    state <= RUN;
                    RUN:     state <= RUN;
                    DRAIN:   if (discard_next == '0) state <= RUN;
                    default: state <= BOOT;
                endcase
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (push),
        .push_data({resp_pc, imem_rdata_i}),
        .pop      (pop),
        .flush    (redirect_i),
        .count    (fifo_count),
        .head     (fifo_head)
    );

`ifdef IF_PERF_CNT_EN
    // Bubbles are cycles where decode could take a word but none is buffered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if_fetch_cnt_o  <= '0;
            if_bubble_cnt_o <= '0;
        end else begin
            if (pop) if_fetch_cnt_o <= if_fetch_cnt_o + 32'd1;
            if (instr_ready_i && !instr_valid_o && (state != BOOT)) begin
                if_bubble_cnt_o <= if_bubble_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
